// File: rtl/usb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : usb_pkg                                                |
// | Description : Shared types and CRC constants for the USB RX decoder. |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package usb_pkg;

  // Packet identifiers carried in the low nibble of the PID byte
  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_PID  = 2'd1,
    ERR_LEN  = 2'd2,
    ERR_CRC  = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    PC_BAD   = 2'd0,
    PC_TOKEN = 2'd1,
    PC_DATA  = 2'd2,
    PC_HSK   = 2'd3
  } pid_class_t;

  // Serial CRCs shift data LSB first; the transmitted CRC is the inverted
  // remainder, so a good packet always leaves the fixed residue behind.
  localparam logic [4:0]  CRC5_POLY     = 5'b00101;
  localparam logic [4:0]  CRC5_INIT     = 5'b11111;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  // Map a PID nibble to the packet family that fixes its payload layout
  function automatic pid_class_t pid_class(input logic [3:0] p);
    case (p)
      PID_OUT, PID_IN, PID_SETUP:   pid_class = PC_TOKEN;
      PID_DATA0, PID_DATA1:         pid_class = PC_DATA;
      PID_ACK, PID_NAK, PID_STALL:  pid_class = PC_HSK;
      default:                      pid_class = PC_BAD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rx_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : usb_rx_decoder_if                                      |
// | Description : Serial bit input and decoded-packet result bundle.     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface usb_rx_decoder_if #(
  parameter int MAX_BYTES = 8
);
  localparam int LEN_W = $clog2(MAX_BYTES + 1);

  logic                   inb;
  logic                   recving;
  logic                   pause;
  logic                   got_data;
  logic                   pkt_valid;
  logic                   err;
  logic [1:0]             err_code;
  logic [3:0]             pid;
  logic [6:0]             addr;
  logic [3:0]             endp;
  logic [8*MAX_BYTES-1:0] data;
  logic [LEN_W-1:0]       data_len;
  logic                   overrun;

  // Line side / consumer: supplies bits and acknowledges results
  modport master (
    output inb, recving, pause, got_data,
    input  pkt_valid, err, err_code, pid, addr, endp, data, data_len, overrun
  );

  // Decoder side
  modport slave (
    input  inb, recving, pause, got_data,
    output pkt_valid, err, err_code, pid, addr, endp, data, data_len, overrun
  );
endinterface
`default_nettype wire

// File: rtl/usb_crc_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : usb_crc_serial                                         |
// | Description : Bit-serial CRC register, one data bit per enabled clk. |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module usb_crc_serial #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] crc_o
);

  logic [WIDTH-1:0] crc_q;
  logic             w_fb;

  assign w_fb  = bit_i ^ crc_q[WIDTH-1];
  assign crc_o = crc_q;

  // Galois LFSR update; clear has priority so a new packet starts from INIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= INIT;
    end else if (clr_i) begin
      crc_q <= INIT;
    end else if (en_i) begin
      crc_q <= {crc_q[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_rx_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : usb_rx_decoder                                         |
// | Description : Decodes a de-stuffed USB packet bitstream into PID,    |
// |               token fields or payload, with PID/length/CRC checks.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module usb_rx_decoder
  import usb_pkg::*;
#(
  parameter int MAX_BYTES = 8
) (
  input  logic            clk,
  input  logic            rst,
  usb_rx_decoder_if.slave bus
);

  localparam int DW      = 8 * MAX_BYTES;
  // Stored post-PID bits: the payload, or at least the 11 token field bits
  localparam int BUFW    = (DW > 11) ? DW : 11;
  localparam int BIW     = $clog2(BUFW);
  // Longest post-PID run still tracked exactly; beyond it the count saturates
  localparam int LMAX    = DW + 24;
  localparam int CNT_MAX = 8 + LMAX + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int LW      = $clog2(MAX_BYTES + 1);

  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      pidsr_q, pidsr_d;
  logic [BUFW-1:0] buf_q, buf_d;
  logic            recv_prev_q;

  logic            pkt_valid_q;
  logic            err_q;
  err_code_t       err_code_q;
  logic [3:0]      pid_q;
  logic [6:0]      addr_q;
  logic [3:0]      endp_q;
  logic [DW-1:0]   data_q;
  logic [LW-1:0]   data_len_q;
  logic            overrun_q;

  logic            w_accept;
  logic            w_load;
  logic            w_clear;
  logic [CW-1:0]   w_post_len;
  logic [CW-1:0]   w_nb_full;
  pid_class_t      w_class;
  err_code_t       w_err_code;
  logic [DW-1:0]   w_data;
  logic [4:0]      w_crc5;
  logic [15:0]     w_crc16;
  logic            w_crc_en;
  logic            w_crc_clr;

  assign w_accept   = bus.recving && !bus.pause;
  assign w_post_len = (cnt_q >= CW'(8)) ? (cnt_q - CW'(8)) : '0;
  assign w_nb_full  = (w_post_len - CW'(16)) >> 3;
  assign w_class    = pid_class(pidsr_q[3:0]);

  // CRCs see only post-PID bits and restart whenever the FSM sits in IDLE
  assign w_crc_clr  = (state_q == IDLE);
  assign w_crc_en   = (state_q == RECV) && w_accept && (cnt_q >= CW'(8));

  usb_crc_serial #(
    .WIDTH (5),
    .POLY  (CRC5_POLY),
    .INIT  (CRC5_INIT)
  ) u_crc5 (
    .clk   (clk),
    .rst   (rst),
    .clr_i (w_crc_clr),
    .en_i  (w_crc_en),
    .bit_i (bus.inb),
    .crc_o (w_crc5)
  );

  usb_crc_serial #(
    .WIDTH (16),
    .POLY  (CRC16_POLY),
    .INIT  (CRC16_INIT)
  ) u_crc16 (
    .clk   (clk),
    .rst   (rst),
    .clr_i (w_crc_clr),
    .en_i  (w_crc_en),
    .bit_i (bus.inb),
    .crc_o (w_crc16)
  );

  // FSM state register together with the bit counter and shift storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pidsr_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pidsr_q <= pidsr_d;
      buf_q   <= buf_d;
    end
  end

  // Next state and bit capture; bits past the storage window are only counted
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pidsr_d = pidsr_q;
    buf_d   = buf_q;
    w_load  = 1'b0;
    w_clear = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (w_accept) begin
          state_d    = RECV;
          cnt_d      = CW'(1);
          pidsr_d[0] = bus.inb;
        end
      end
      RECV: begin
        if (!bus.recving) begin
          state_d = HOLD;
          w_load  = 1'b1;
        end else if (w_accept) begin
          if (cnt_q < CW'(8)) begin
            pidsr_d[cnt_q[2:0]] = bus.inb;
          end else if (w_post_len < CW'(BUFW)) begin
            buf_d[w_post_len[BIW-1:0]] = bus.inb;
          end
          if (cnt_q < CW'(CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.got_data) begin
          w_clear = 1'b1;
          state_d = bus.recving ? DROP : IDLE;
        end
      end
      DROP: begin
        if (!bus.recving) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Packet verdict with PID > LEN > CRC priority
  always_comb begin
    w_err_code = ERR_NONE;
    if (cnt_q < CW'(8)) begin
      w_err_code = ERR_LEN;
    end else if ((pidsr_q[7:4] != ~pidsr_q[3:0]) || (w_class == PC_BAD)) begin
      w_err_code = ERR_PID;
    end else begin
      case (w_class)
        PC_TOKEN: begin
          if (w_post_len != CW'(16))           w_err_code = ERR_LEN;
          else if (w_crc5 != CRC5_RESIDUE)     w_err_code = ERR_CRC;
        end
        PC_DATA: begin
          if ((w_post_len < CW'(16)) || (w_post_len[2:0] != 3'd0) ||
              (w_post_len > CW'(DW + 16)))     w_err_code = ERR_LEN;
          else if (w_crc16 != CRC16_RESIDUE)   w_err_code = ERR_CRC;
        end
        PC_HSK: begin
          if (w_post_len != '0)                w_err_code = ERR_LEN;
        end
        default: w_err_code = ERR_PID;
      endcase
    end
  end

  // Payload bytes at or above the received count read as zero
  always_comb begin
    w_data = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (CW'(k) < w_nb_full) begin
        w_data[8*k +: 8] = buf_q[8*k +: 8];
      end
    end
  end

  // Result registers: captured on entry to HOLD, cleared after acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      pid_q       <= '0;
      addr_q      <= '0;
      endp_q      <= '0;
      data_q      <= '0;
      data_len_q  <= '0;
    end else if (w_load) begin
      pkt_valid_q <= (w_err_code == ERR_NONE);
      err_q       <= (w_err_code != ERR_NONE);
      err_code_q  <= w_err_code;
      pid_q       <= (w_err_code == ERR_NONE) ? pidsr_q[3:0] : 4'h0;
      if ((w_err_code == ERR_NONE) && (w_class == PC_TOKEN)) begin
        addr_q <= buf_q[6:0];
        endp_q <= buf_q[10:7];
      end else begin
        addr_q <= '0;
        endp_q <= '0;
      end
      if ((w_err_code == ERR_NONE) && (w_class == PC_DATA)) begin
        data_q     <= w_data;
        data_len_q <= w_nb_full[LW-1:0];
      end else begin
        data_q     <= '0;
        data_len_q <= '0;
      end
    end else if (w_clear) begin
      pkt_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      pid_q       <= '0;
      addr_q      <= '0;
      endp_q      <= '0;
      data_q      <= '0;
      data_len_q  <= '0;
    end
  end

  // One-cycle overrun flag on the rising edge of recving while a result waits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      recv_prev_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      recv_prev_q <= bus.recving;
      overrun_q   <= (state_q == HOLD) && bus.recving && !recv_prev_q;
    end
  end

  assign bus.pkt_valid = pkt_valid_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.pid       = pid_q;
  assign bus.addr      = addr_q;
  assign bus.endp      = endp_q;
  assign bus.data      = data_q;
  assign bus.data_len  = data_len_q;
  assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: doc/usb_rx_decoder.md
USB_RX_DECODER -- requirements
Module: usb_rx_decoder

Interface
REQ-001 SHALL have parameter: MAX_BYTES, 8, maximum DATA payload bytes (1..64).
REQ-002 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- inb  in  1  serial bit, valid when recving && !pause.
- recving  in  1  high for the duration of a packet.
- pause  in  1  current cycle carries no bit (bit-stuff slot).
- got_data  in  1  consumer acknowledges the held result.
- pkt_valid  out  1  good packet held.
- err  out  1  bad packet held.
- err_code  out  2  0 NONE, 1 PID, 2 LEN, 3 CRC.
- pid  out  4  decoded PID.
- addr  out  7  token address.
- endp  out  4  token endpoint.
- data  out  8*MAX_BYTES  payload; byte k at [8k+7:8k].
- data_len  out  $clog2(MAX_BYTES+1)  payload byte count.
- overrun  out  1  one-cycle pulse: packet dropped.

Function
REQ-003 SHALL accept a bit on every cycle with recving && !pause; fields arrive LSB first.
REQ-004 SHALL treat the first 8 bits as PID byte: pid[3:0], then check nibble, which must equal ~pid.
REQ-005 SHALL support OUT 0001, IN 1001, SETUP 1101 (token); DATA0 0011, DATA1 1011 (data); ACK 0010, NAK 1010, STALL 1110 (handshake); any other PID -> ERR_PID.
REQ-006 SHALL require post-PID bit count L: token L=16 (addr7, endp4, crc5); handshake L=0; data L=8n+16 with 0<=n<=MAX_BYTES; else ERR_LEN.
REQ-007 SHALL stop storing bits once the count exceeds 8*MAX_BYTES+24, keep counting saturated, and report ERR_LEN.
REQ-008 SHALL check CRC by residue over all post-PID bits: CRC5 x^5+x^2+1, init 11111, residue 01100; CRC16 x^16+x^15+x^2+1, init FFFF, residue 800D; mismatch -> ERR_CRC.
REQ-009 SHALL report one error only, priority PID > LEN > CRC.
REQ-010 SHALL use FSM states IDLE, RECV, HOLD, DROP.
REQ-011 IDLE->RECV on first accepted bit; RECV->HOLD on first cycle with recving low (pause ignored).
REQ-012 SHALL present results from the first HOLD cycle, one cycle after recving falls, and hold them stable until got_data is sampled high.
REQ-013 HOLD + got_data: outputs cleared next cycle; ->IDLE if recving low, else ->DROP.
REQ-014 SHALL pulse overrun once per packet that starts while in HOLD; DROP->IDLE when recving low; dropped bits are ignored.
REQ-015 SHALL zero data bytes >= data_len; addr/endp 0 for non-tokens; on err, pid/addr/endp/data/data_len are 0.
REQ-016 SHALL treat fewer than 8 bits received as ERR_LEN with pid=0.

Reset
REQ-017 SHALL, while rst is high, force state IDLE, all outputs 0, and clear counters, CRC and shift registers, including mid-packet.
REQ-018 SHALL, after rst release during an active recving, treat that packet as starting in IDLE (no special resync).

Structure
REQ-019 SHALL place pid_t, err_code_t, state enum and CRC poly/init/residue constants in shared package usb_pkg.
REQ-020 SHALL implement CRC in one sub-module usb_crc_serial (parameters WIDTH, POLY, INIT), instantiated for CRC5 and CRC16.

Verification
REQ-021 OUT addr 7'h05 endp 4'h2 with correct CRC5 -> pkt_valid=1, pid=4'b0001, addr=7'h05, endp=4'h2, err=0.
REQ-022 DATA1 bytes A5,3C,FF + good CRC16, MAX_BYTES=8, 2 pause cycles mid-packet -> data[23:0]=24'hFF3CA5, data_len=3, pid=4'b1011; same data with one CRC bit flipped -> err=1, err_code=3.
REQ-023 PID byte with pid 0011 and check nibble 0011 -> err_code=1; ACK followed by 8 extra bits -> err_code=2; 9-byte DATA0 at MAX_BYTES=8 -> err_code=2.
REQ-024 Second packet starts during HOLD, got_data withheld -> overrun pulse of 1 cycle, first result unchanged; after got_data, FSM waits in DROP until recving low.
REQ-025 rst asserted at bit 30 of a DATA0 -> all outputs 0 immediately; next clean NAK -> pkt_valid=1, pid=4'b1010.
